// File: rtl/sm_divider.sv
// sm_divider: sequential restoring sign-magnitude divider, 5-bit dividend by 3-bit divisor, one quotient bit per clock.
module sm_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] dividend,
    input  logic [2:0] divisor,
    output logic [4:0] quotient,
    output logic [2:0] remainder,
    output logic       zeroFlag,
    output logic       divByZero,
    output logic       busy,
    output logic       done
);
    typedef enum logic {IDLE, CALC} state_t;
    state_t state, state_next;
    logic       dvd_sign, dvs_sign;
    logic [3:0] dvd_mag, q, q_next;
    logic [1:0] dvs_mag, r, r_next, i;
    logic [2:0] t, diff;
    logic       ge;
    always_comb begin
        t          = {r, dvd_mag[i]};
        diff       = t - {1'b0, dvs_mag};
        ge         = t >= {1'b0, dvs_mag};
        r_next     = ge ? diff[1:0] : t[1:0];
        q_next     = q;
        q_next[i]  = ge;
        state_next = state == IDLE ? ((start && divisor[1:0] != 2'd0) ? CALC : IDLE)
                                   : (i == 2'd0 ? IDLE : CALC);
    end
    assign busy = state == CALC;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            quotient  <= '0;
            remainder <= '0;
            zeroFlag  <= 1'b0;
            divByZero <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (state == IDLE && start) begin
                if (divisor[1:0] != 2'd0) begin
                    dvd_sign <= dividend[4];
                    dvd_mag  <= dividend[3:0];
                    dvs_sign <= divisor[2];
                    dvs_mag  <= divisor[1:0];
                    r        <= '0;
                    q        <= '0;
                    i        <= 2'd3;
                end else begin
                    quotient  <= '0;
                    remainder <= '0;
                    zeroFlag  <= 1'b1;
                    divByZero <= 1'b1;
                    done      <= 1'b1;
                end
            end else if (state == CALC) begin
                r <= r_next;
                q <= q_next;
                i <= i - 2'd1;
                if (i == 2'd0) begin
                    quotient  <= {dvd_sign ^ dvs_sign, q_next};
                    remainder <= {dvd_sign, r_next};
                    zeroFlag  <= q_next == 4'd0;
                    divByZero <= 1'b0;
                    done      <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sm_divider.sv
// tb_sm_divider: randomized and directed checks of sm_divider against an arithmetic reference model.
module tb_sm_divider;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [4:0] dividend = '0, quotient;
    logic [2:0] divisor = '0, remainder;
    logic       zeroFlag, divByZero, busy, done;
    int passed = 0, total = 0;

    sm_divider dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .zeroFlag(zeroFlag),
        .divByZero(divByZero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [4:0] a, input logic [2:0] b, output logic [4:0] q,
                                  output logic [2:0] r, output logic z, output logic dz);
        int ma = int'(a[3:0]);
        int mb = int'(b[1:0]);
        if (mb == 0) begin
            q = '0; r = '0; z = 1'b1; dz = 1'b1;
        end else begin
            q  = {a[4] ^ b[2], 4'(ma / mb)};
            r  = {a[4], 2'(ma % mb)};
            z  = (ma / mb) == 0;
            dz = 1'b0;
        end
    endfunction

    // Called one step after a rising edge with the DUT idle; returns one step after the edge following done.
    task automatic run_op(input logic [4:0] a, input logic [2:0] b, output int lat, output int bc,
                          output logic [4:0] q, output logic [2:0] r, output logic z,
                          output logic dz, output logic pulse_ok);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 5'($urandom);
        divisor  = 3'($urandom);
        lat = 0;
        bc  = 0;
        while (!done && lat < 10) begin
            bc += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
        bc += int'(busy);
        q = quotient; r = remainder; z = zeroFlag; dz = divByZero;
        @(posedge clk); #1;
        pulse_ok = !done;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({quotient, remainder, zeroFlag, divByZero, busy, done} !== 12'd0)
            $display("FAIL reset_state got q=%b r=%b z=%b dz=%b busy=%b done=%b want all zero",
                     quotient, remainder, zeroFlag, divByZero, busy, done);
        else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors;
        int lat, bc;
        logic [4:0] q; logic [2:0] r; logic z, dz, pok;
        run_op(5'b0_1001, 3'b0_11, lat, bc, q, r, z, dz, pok);
        total++;
        if (lat != 4 || bc != 4) $display("FAIL vec1_timing got lat=%0d busy=%0d want 4/4", lat, bc);
        else passed++;
        total++;
        if ({q, r, z, dz} !== {5'b0_0011, 3'b0_00, 1'b0, 1'b0})
            $display("FAIL vec1_result got q=%b r=%b z=%b dz=%b want 00011 000 0 0", q, r, z, dz);
        else passed++;
        total++;
        if (!pok) $display("FAIL vec1_done_width got done still 1 want 0");
        else passed++;
        run_op(5'b1_1011, 3'b0_10, lat, bc, q, r, z, dz, pok);
        total++;
        if ({q, r, z, dz} !== {5'b1_0101, 3'b1_01, 1'b0, 1'b0})
            $display("FAIL vec2_result got q=%b r=%b z=%b dz=%b want 10101 101 0 0", q, r, z, dz);
        else passed++;
        run_op(5'b0_0010, 3'b1_11, lat, bc, q, r, z, dz, pok);
        total++;
        if ({q, r, z, dz} !== {5'b1_0000, 3'b0_10, 1'b1, 1'b0})
            $display("FAIL vec3_neg_zero got q=%b r=%b z=%b dz=%b want 10000 010 1 0", q, r, z, dz);
        else passed++;
    endtask

    task automatic test_div_zero;
        int lat, bc;
        logic [4:0] q; logic [2:0] r; logic z, dz, pok;
        run_op(5'b0_0110, 3'b1_00, lat, bc, q, r, z, dz, pok);
        total++;
        if (lat != 0 || bc != 0) $display("FAIL dbz_timing got lat=%0d busy=%0d want 0/0", lat, bc);
        else passed++;
        total++;
        if ({q, r, z, dz} !== {5'd0, 3'd0, 1'b1, 1'b1})
            $display("FAIL dbz_result got q=%b r=%b z=%b dz=%b want 00000 000 1 1", q, r, z, dz);
        else passed++;
        total++;
        if (!pok) $display("FAIL dbz_done_width got done still 1 want 0");
        else passed++;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dividend = 5'($urandom);
            divisor  = {1'($urandom), 2'b00};
            @(posedge clk); #1;
            total++;
            if (!(done && divByZero && zeroFlag && !busy))
                $display("FAIL dbz_stream cycle %0d got done=%b dz=%b z=%b busy=%b want 1 1 1 0",
                         k, done, divByZero, zeroFlag, busy);
            else passed++;
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_round_trip;
        int lat, bc;
        logic [4:0] q; logic [2:0] r; logic z, dz, pok;
        logic [2:0] a, b;
        for (int ai = 0; ai < 8; ai++) begin
            for (int bi = 0; bi < 8; bi++) begin
                a = 3'(ai);
                b = 3'(bi);
                if (b[1:0] != 2'd0) begin
                    run_op({a[2] ^ b[2], 4'(a[1:0] * b[1:0])}, b, lat, bc, q, r, z, dz, pok);
                    total++;
                    if ({q, r, z, dz} !== {a[2], 2'b00, a[1:0], a[2] ^ b[2], 2'b00, a[1:0] == 2'd0, 1'b0})
                        $display("FAIL round_trip a=%b b=%b got q=%b r=%b z=%b dz=%b", a, b, q, r, z, dz);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_random;
        int lat, bc;
        logic [4:0] q, eq, a; logic [2:0] r, er, b; logic z, dz, pok, ez, edz;
        for (int n = 0; n < 40; n++) begin
            a = 5'($urandom);
            b = 3'($urandom);
            model(a, b, eq, er, ez, edz);
            run_op(a, b, lat, bc, q, r, z, dz, pok);
            total++;
            if ({q, r, z, dz} !== {eq, er, ez, edz} || lat != (edz ? 0 : 4) || bc != (edz ? 0 : 4) || !pok)
                $display("FAIL random %b/%b got q=%b r=%b z=%b dz=%b lat=%0d busy=%0d want q=%b r=%b z=%b dz=%b",
                         a, b, q, r, z, dz, lat, bc, eq, er, ez, edz);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] qa[$], eq;
        logic [2:0] qb[$], er;
        logic ez, edz;
        int dones = 0;
        start = 1'b1;
        for (int k = 0; k < 25; k++) begin
            dividend = 5'($urandom);
            divisor  = {1'($urandom), 2'($urandom_range(1, 3))};
            if (k % 5 == 0) begin
                qa.push_back(dividend);
                qb.push_back(divisor);
            end
            @(posedge clk); #1;
            if (done) begin
                dones++;
                total++;
                if (qa.size() == 0) $display("FAIL b2b_extra_done at edge %0d got done=1 want 0", k);
                else begin
                    model(qa[0], qb[0], eq, er, ez, edz);
                    if (k % 5 != 4 || {quotient, remainder, zeroFlag, divByZero} !== {eq, er, ez, edz})
                        $display("FAIL b2b_result edge %0d got q=%b r=%b z=%b want q=%b r=%b z=%b at edge%%5==4",
                                 k, quotient, remainder, zeroFlag, eq, er, ez);
                    else passed++;
                    void'(qa.pop_front());
                    void'(qb.pop_front());
                end
            end
        end
        start = 1'b0;
        total++;
        if (dones != 5) $display("FAIL b2b_count got %0d results want 5", dones);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat, bc;
        logic [4:0] q; logic [2:0] r; logic z, dz, pok;
        logic seen = 1'b0;
        run_op(5'b0_1001, 3'b0_11, lat, bc, q, r, z, dz, pok);
        dividend = 5'b0_1111;
        divisor  = 3'b0_01;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({quotient, remainder, zeroFlag, divByZero, busy, done} !== 12'd0)
            $display("FAIL mid_reset_state got q=%b r=%b z=%b dz=%b busy=%b done=%b want all zero",
                     quotient, remainder, zeroFlag, divByZero, busy, done);
        else passed++;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            seen |= done | busy;
        end
        total++;
        if (seen) $display("FAIL mid_reset_abort got done/busy=1 after reset want 0");
        else passed++;
        run_op(5'b0_1111, 3'b0_01, lat, bc, q, r, z, dz, pok);
        total++;
        if ({q, r, z, dz, lat} !== {5'b0_1111, 3'b0_00, 1'b0, 1'b0, 4})
            $display("FAIL after_reset got q=%b r=%b z=%b dz=%b lat=%0d want 01111 000 0 0 4", q, r, z, dz, lat);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_div_zero;
        test_round_trip;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
